// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM encodings, master index type and response codes for the 2:1 AXI-Lite arbiter
package axi_arb_pkg;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;
    typedef logic mst_t;
    localparam logic [1:0] OKAY = 2'b00;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way arbiter, round-robin on last grant or fixed priority with m0 highest
module rr_pick2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  mst_t       last,
    input  logic       rr,
    output mst_t       gnt
);
    assign gnt = req[1] && (!req[0] || (rr && !last));
endmodule

// File: rtl/axi_lite_arb2.sv
// axi_lite_arb2: two AXI-Lite requesters onto one slave, independent read and write arbitration
module axi_lite_arb2
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    output logic [1:0]          m0_bresp,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready
);
    r_state_t r_state;
    w_state_t w_state;
    mst_t     rgnt, rlast, rpick, wgnt, wlast, wpick;
    logic     aw_done, w_done, aw_hs, w_hs, ra, wa, wr, wb;

    rr_pick2 u_rpick (.req({m1_arvalid, m0_arvalid}), .last(rlast), .rr(RR != 0), .gnt(rpick));
    rr_pick2 u_wpick (.req({m1_awvalid && m1_wvalid, m0_awvalid && m0_wvalid}), .last(wlast), .rr(RR != 0), .gnt(wpick));

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state <= R_IDLE;
            rgnt    <= 1'b0;
            rlast   <= 1'b1;
        end else case (r_state)
            R_IDLE: if (m0_arvalid || m1_arvalid) begin
                rgnt    <= rpick;
                rlast   <= rpick;
                r_state <= R_ADDR;
            end
            R_ADDR: if (s_arvalid && s_arready) r_state <= R_DATA;
            R_DATA: if (s_rvalid && s_rready) r_state <= R_IDLE;
            default: r_state <= R_IDLE;
        endcase

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            w_state <= W_IDLE;
            wgnt    <= 1'b0;
            wlast   <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else case (w_state)
            W_IDLE: if ((m0_awvalid && m0_wvalid) || (m1_awvalid && m1_wvalid)) begin
                wgnt    <= wpick;
                wlast   <= wpick;
                w_state <= W_REQ;
            end
            W_REQ: begin
                aw_done <= aw_done || aw_hs;
                w_done  <= w_done || w_hs;
                if ((aw_done || aw_hs) && (w_done || w_hs)) w_state <= W_RESP;
            end
            W_RESP: if (s_bvalid && s_bready) begin
                w_state <= W_IDLE;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            default: w_state <= W_IDLE;
        endcase

    assign ra = r_state == R_ADDR;
    assign wr = r_state == R_DATA;
    assign s_araddr   = rgnt ? m1_araddr : m0_araddr;
    assign s_arvalid  = ra && (rgnt ? m1_arvalid : m0_arvalid);
    assign m0_arready = ra && !rgnt && s_arready;
    assign m1_arready = ra && rgnt && s_arready;
    assign s_rready   = wr && (rgnt ? m1_rready : m0_rready);
    assign m0_rvalid  = wr && !rgnt && s_rvalid;
    assign m1_rvalid  = wr && rgnt && s_rvalid;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign m0_rresp   = s_rresp;
    assign m1_rresp   = s_rresp;

    // Completed channels stay masked until the response so the slave never sees a repeat.
    assign wa = w_state == W_REQ && !aw_done;
    assign wb = w_state == W_REQ && !w_done;
    assign s_awaddr   = wgnt ? m1_awaddr : m0_awaddr;
    assign s_wdata    = wgnt ? m1_wdata : m0_wdata;
    assign s_wstrb    = wgnt ? m1_wstrb : m0_wstrb;
    assign s_awvalid  = wa && (wgnt ? m1_awvalid : m0_awvalid);
    assign s_wvalid   = wb && (wgnt ? m1_wvalid : m0_wvalid);
    assign aw_hs      = s_awvalid && s_awready;
    assign w_hs       = s_wvalid && s_wready;
    assign m0_awready = wa && !wgnt && s_awready;
    assign m1_awready = wa && wgnt && s_awready;
    assign m0_wready  = wb && !wgnt && s_wready;
    assign m1_wready  = wb && wgnt && s_wready;
    assign s_bready   = w_state == W_RESP && (wgnt ? m1_bready : m0_bready);
    assign m0_bvalid  = w_state == W_RESP && !wgnt && s_bvalid;
    assign m1_bvalid  = w_state == W_RESP && wgnt && s_bvalid;
    assign m0_bresp   = s_bresp;
    assign m1_bresp   = s_bresp;
endmodule

// File: tb/tb_axi_lite_arb2.sv
// tb_axi_lite_arb2: directed checks of a round-robin and a fixed-priority arbiter driven by one stimulus
module tb_axi_lite_arb2;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_arvalid, m1_arvalid, m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid;
  logic        m0_rready, m1_rready, m0_bready, m1_bready;
  logic        s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
  logic [1:0]  s_rresp, s_bresp;
  logic [31:0] r_s_araddr, r_s_awaddr, r_s_wdata, r_m0_rdata, r_m1_rdata;
  logic [3:0]  r_s_wstrb;
  logic [1:0]  r_m0_rresp, r_m1_rresp, r_m0_bresp, r_m1_bresp;
  logic        r_s_arvalid, r_s_awvalid, r_s_wvalid, r_s_rready, r_s_bready;
  logic        r_m0_arready, r_m1_arready, r_m0_awready, r_m1_awready, r_m0_wready, r_m1_wready;
  logic        r_m0_rvalid, r_m1_rvalid, r_m0_bvalid, r_m1_bvalid;
  logic [31:0] f_s_araddr, f_s_awaddr, f_s_wdata, f_m0_rdata, f_m1_rdata;
  logic [3:0]  f_s_wstrb;
  logic [1:0]  f_m0_rresp, f_m1_rresp, f_m0_bresp, f_m1_bresp;
  logic        f_s_arvalid, f_s_awvalid, f_s_wvalid, f_s_rready, f_s_bready;
  logic        f_m0_arready, f_m1_arready, f_m0_awready, f_m1_awready, f_m0_wready, f_m1_wready;
  logic        f_m0_rvalid, f_m1_rvalid, f_m0_bvalid, f_m1_bvalid;
  logic [14:0] r_vr, f_vr;
  int checks = 0, failures = 0;
  int r_n, f_n, r_b0, r_b1, f_b0, f_b1;
  logic [31:0] r_d [2];
  logic [31:0] f_d [2];

  always #5 clk = ~clk;

  assign r_vr = {r_s_arvalid, r_s_awvalid, r_s_wvalid, r_s_rready, r_s_bready, r_m0_arready, r_m1_arready,
                 r_m0_awready, r_m1_awready, r_m0_wready, r_m1_wready, r_m0_rvalid, r_m1_rvalid, r_m0_bvalid, r_m1_bvalid};
  assign f_vr = {f_s_arvalid, f_s_awvalid, f_s_wvalid, f_s_rready, f_s_bready, f_m0_arready, f_m1_arready,
                 f_m0_awready, f_m1_awready, f_m0_wready, f_m1_wready, f_m0_rvalid, f_m1_rvalid, f_m0_bvalid, f_m1_bvalid};

  axi_lite_arb2 #(.ADDR_W(32), .DATA_W(32), .RR(1)) u_rr (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(r_m0_arready),
    .m0_rdata(r_m0_rdata), .m0_rresp(r_m0_rresp), .m0_rvalid(r_m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(r_m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(r_m0_wready),
    .m0_bresp(r_m0_bresp), .m0_bvalid(r_m0_bvalid), .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(r_m1_arready),
    .m1_rdata(r_m1_rdata), .m1_rresp(r_m1_rresp), .m1_rvalid(r_m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(r_m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(r_m1_wready),
    .m1_bresp(r_m1_bresp), .m1_bvalid(r_m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(r_s_araddr), .s_arvalid(r_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(r_s_rready),
    .s_awaddr(r_s_awaddr), .s_awvalid(r_s_awvalid), .s_awready(s_awready),
    .s_wdata(r_s_wdata), .s_wstrb(r_s_wstrb), .s_wvalid(r_s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(r_s_bready)
  );

  axi_lite_arb2 #(.ADDR_W(32), .DATA_W(32), .RR(0)) u_fp (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready),
    .m0_rdata(f_m0_rdata), .m0_rresp(f_m0_rresp), .m0_rvalid(f_m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(f_m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(f_m0_wready),
    .m0_bresp(f_m0_bresp), .m0_bvalid(f_m0_bvalid), .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready),
    .m1_rdata(f_m1_rdata), .m1_rresp(f_m1_rresp), .m1_rvalid(f_m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(f_m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(f_m1_wready),
    .m1_bresp(f_m1_bresp), .m1_bvalid(f_m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(f_s_araddr), .s_arvalid(f_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(f_s_rready),
    .s_awaddr(f_s_awaddr), .s_awvalid(f_s_awvalid), .s_awready(s_awready),
    .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb), .s_wvalid(f_s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(f_s_bready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_all(input logic v);
    {m0_arvalid, m1_arvalid, m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid} = {6{v}};
    {m0_rready, m1_rready, m0_bready, m1_bready} = {4{v}};
    {s_arready, s_awready, s_wready, s_rvalid, s_bvalid} = {5{v}};
  endtask

  initial begin
    rst = 1'b1;
    {m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata, s_rdata} = '0;
    {m0_wstrb, m1_wstrb, s_rresp, s_bresp} = '0;
    drive_all(1'b0);
    #1 rst = 1'b0;
    drive_all(1'b1);
    #2;
    chk("rst_async_rr", r_vr === 15'd0, r_vr, 15'd0);
    chk("rst_async_fp", f_vr === 15'd0, f_vr, 15'd0);
    tick;
    tick;
    chk("rst_hold_rr", r_vr === 15'd0, r_vr, 15'd0);
    chk("rst_hold_fp", f_vr === 15'd0, f_vr, 15'd0);
    drive_all(1'b0);
    rst = 1'b1;
    tick;
    {m0_awvalid, m0_wvalid, m1_awvalid, m1_wvalid} = 4'hF;
    m0_awaddr = 32'hA000_03F8; m1_awaddr = 32'hA000_03F8;
    m0_wdata = 32'h41; m1_wdata = 32'h42; m0_wstrb = 4'h1; m1_wstrb = 4'h1;
    {s_awready, s_wready, s_bvalid, m0_bready, m1_bready} = 5'h1F;
    {r_n, f_n, r_b0, r_b1, f_b0, f_b1} = '0;
    r_d[0] = '0; r_d[1] = '0; f_d[0] = '0; f_d[1] = '0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (r_s_wvalid) begin if (r_n < 2) r_d[r_n] = r_s_wdata; r_n++; end
      if (f_s_wvalid) begin if (f_n < 2) f_d[f_n] = f_s_wdata; f_n++; end
      r_b0 += int'(r_m0_bvalid); r_b1 += int'(r_m1_bvalid);
      f_b0 += int'(f_m0_bvalid); f_b1 += int'(f_m1_bvalid);
    end
    drive_all(1'b0);
    chk("rr_wcount", r_n === 2, r_n, 2);
    chk("rr_first_w", r_d[0] === 32'h41, r_d[0], 32'h41);
    chk("rr_second_w", r_d[1] === 32'h42, r_d[1], 32'h42);
    chk("rr_m0_b", r_b0 === 1, r_b0, 1);
    chk("rr_m1_b", r_b1 === 1, r_b1, 1);
    chk("fp_first_w", f_d[0] === 32'h41, f_d[0], 32'h41);
    chk("fp_second_w", f_d[1] === 32'h41, f_d[1], 32'h41);
    chk("fp_m0_b", f_b0 === 2, f_b0, 2);
    chk("fp_m1_b", f_b1 === 0, f_b1, 0);
    m0_arvalid = 1'b1; m0_araddr = 32'h1000_0000; s_arready = 1'b1;
    chk("rd_arb_cycle", r_s_arvalid === 1'b0, r_s_arvalid, 0);
    chk("rd_arb_ready", r_m0_arready === 1'b0, r_m0_arready, 0);
    tick;
    chk("rd_s_arvalid", r_s_arvalid === 1'b1, r_s_arvalid, 1);
    chk("rd_s_araddr", r_s_araddr === 32'h1000_0000, r_s_araddr, 32'h1000_0000);
    chk("rd_m0_arready", r_m0_arready === 1'b1, r_m0_arready, 1);
    chk("rd_m1_arready", r_m1_arready === 1'b0, r_m1_arready, 0);
    tick;
    m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; m0_rready = 1'b1;
    #1;
    chk("rd_m0_rvalid", r_m0_rvalid === 1'b1, r_m0_rvalid, 1);
    chk("rd_m0_rdata", r_m0_rdata === 32'hDEAD_BEEF, r_m0_rdata, 32'hDEAD_BEEF);
    chk("rd_m1_rvalid", r_m1_rvalid === 1'b0, r_m1_rvalid, 0);
    chk("rd_s_rready", r_s_rready === 1'b1, r_s_rready, 1);
    tick;
    chk("rd_idle_rvalid", r_m0_rvalid === 1'b0, r_m0_rvalid, 0);
    drive_all(1'b0);
    {m0_awvalid, m0_wvalid} = 2'b11; m0_awaddr = 32'h0000_0040; m0_wdata = 32'h55; m0_wstrb = 4'hF;
    s_awready = 1'b1;
    tick;
    chk("aw_first_valid", r_s_awvalid === 1'b1, r_s_awvalid, 1);
    chk("aw_first_addr", r_s_awaddr === 32'h0000_0040, r_s_awaddr, 32'h40);
    chk("aw_w_valid", r_s_wvalid === 1'b1, r_s_wvalid, 1);
    chk("aw_m0_awready", r_m0_awready === 1'b1, r_m0_awready, 1);
    chk("aw_m0_wready", r_m0_wready === 1'b0, r_m0_wready, 0);
    tick;
    chk("aw_no_dup1", r_s_awvalid === 1'b0, r_s_awvalid, 0);
    chk("aw_w_hold", r_s_wvalid === 1'b1, r_s_wvalid, 1);
    chk("aw_ready_off", r_m0_awready === 1'b0, r_m0_awready, 0);
    tick;
    s_wready = 1'b1;
    #1;
    chk("aw_no_dup2", r_s_awvalid === 1'b0, r_s_awvalid, 0);
    chk("aw_m0_wready_late", r_m0_wready === 1'b1, r_m0_wready, 1);
    chk("aw_wdata", r_s_wdata === 32'h55, r_s_wdata, 32'h55);
    chk("aw_wstrb", r_s_wstrb === 4'hF, r_s_wstrb, 4'hF);
    tick;
    {m0_awvalid, m0_wvalid} = 2'b00; s_bvalid = 1'b1; s_bresp = 2'b10; m0_bready = 1'b1;
    #1;
    chk("aw_m0_bvalid", r_m0_bvalid === 1'b1, r_m0_bvalid, 1);
    chk("aw_m0_bresp", r_m0_bresp === 2'b10, r_m0_bresp, 2);
    chk("aw_m1_bvalid", r_m1_bvalid === 1'b0, r_m1_bvalid, 0);
    chk("aw_s_bready", r_s_bready === 1'b1, r_s_bready, 1);
    tick;
    chk("aw_single_b", r_m0_bvalid === 1'b0, r_m0_bvalid, 0);
    drive_all(1'b0);
    s_bresp = 2'b00;
    {s_arready, s_awready, s_wready} = 3'b111;
    m1_arvalid = 1'b1; m1_araddr = 32'h2000_0000;
    {m0_awvalid, m0_wvalid} = 2'b11; m0_awaddr = 32'h3000_0000; m0_wdata = 32'h77;
    tick;
    chk("cc_s_arvalid", r_s_arvalid === 1'b1, r_s_arvalid, 1);
    chk("cc_s_araddr", r_s_araddr === 32'h2000_0000, r_s_araddr, 32'h2000_0000);
    chk("cc_m1_arready", r_m1_arready === 1'b1, r_m1_arready, 1);
    chk("cc_m0_arready", r_m0_arready === 1'b0, r_m0_arready, 0);
    chk("cc_s_awaddr", r_s_awaddr === 32'h3000_0000, r_s_awaddr, 32'h3000_0000);
    chk("cc_m0_awready", r_m0_awready === 1'b1, r_m0_awready, 1);
    chk("cc_m1_awready", r_m1_awready === 1'b0, r_m1_awready, 0);
    tick;
    {m1_arvalid, m0_awvalid, m0_wvalid} = 3'b000;
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678; s_rresp = 2'b01; s_bvalid = 1'b1; m1_rready = 1'b1; m0_bready = 1'b1;
    #1;
    chk("cc_m1_rvalid", r_m1_rvalid === 1'b1, r_m1_rvalid, 1);
    chk("cc_m0_rvalid", r_m0_rvalid === 1'b0, r_m0_rvalid, 0);
    chk("cc_m1_rdata", r_m1_rdata === 32'h1234_5678, r_m1_rdata, 32'h1234_5678);
    chk("cc_m1_rresp", r_m1_rresp === 2'b01, r_m1_rresp, 1);
    chk("cc_m0_bvalid", r_m0_bvalid === 1'b1, r_m0_bvalid, 1);
    chk("cc_m1_bvalid", r_m1_bvalid === 1'b0, r_m1_bvalid, 0);
    tick;
    drive_all(1'b0);
    s_rresp = 2'b00;
    {s_awready, s_wready} = 2'b11;
    {m1_awvalid, m1_wvalid} = 2'b11; m1_awaddr = 32'h0000_0050; m1_wdata = 32'h99;
    tick;
    tick;
    {m1_awvalid, m1_wvalid} = 2'b00; s_bvalid = 1'b1; m1_bready = 1'b1;
    #1;
    chk("rs_pre_bvalid", r_m1_bvalid === 1'b1, r_m1_bvalid, 1);
    rst = 1'b0;
    #1;
    chk("rs_async_rr", r_vr === 15'd0, r_vr, 15'd0);
    chk("rs_async_fp", f_vr === 15'd0, f_vr, 15'd0);
    #2 rst = 1'b1;
    {m1_awvalid, m1_wvalid} = 2'b11; m1_wdata = 32'hAB;
    #1;
    chk("rs_idle_bvalid", r_m1_bvalid === 1'b0, r_m1_bvalid, 0);
    tick;
    chk("rs_m1_awready", r_m1_awready === 1'b1, r_m1_awready, 1);
    chk("rs_s_wdata", r_s_wdata === 32'hAB, r_s_wdata, 32'hAB);
    chk("rs_fp_m1_awready", f_m1_awready === 1'b1, f_m1_awready, 1);
    tick;
    {m1_awvalid, m1_wvalid} = 2'b00;
    #1;
    chk("rs_m1_bvalid", r_m1_bvalid === 1'b1, r_m1_bvalid, 1);
    chk("rs_m0_bvalid", r_m0_bvalid === 1'b0, r_m0_bvalid, 0);
    tick;
    drive_all(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
